// File: rtl/game_flow_controller.sv
// Top-level game sequencer: boot delay, start screen, play/death/respawn cycle,
// lives tracking and timed win/game-over screens. Timing is counted in frames.
module game_flow_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int BOOT_FRAMES  = 2,
  parameter int DEATH_FRAMES = 60,
  parameter int END_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_of_frame,
  input  logic       start_key,
  input  logic       player_hit,
  input  logic       level_done,
  output logic [2:0] game_state,
  output logic [2:0] lives,
  output logic       freeze,
  output logic       new_game,
  output logic       respawn
);

  localparam int MAX_BD     = (BOOT_FRAMES > DEATH_FRAMES) ? BOOT_FRAMES : DEATH_FRAMES;
  localparam int MAX_FRAMES = (MAX_BD > END_FRAMES) ? MAX_BD : END_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_START = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_WIN   = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] frame_inc;
  logic             key_q;
  logic             key_edge;
  logic             boot_tmo;
  logic             death_tmo;
  logic             end_tmo;

  // Timeouts compare the incremented count, so the state changes on the
  // cycle right after the Nth frame pulse.
  always_comb begin
    key_edge  = start_key & ~key_q;
    frame_inc = frame_cnt + CNT_W'(1);
    boot_tmo  = start_of_frame && (frame_inc == CNT_W'(BOOT_FRAMES));
    death_tmo = start_of_frame && (frame_inc == CNT_W'(DEATH_FRAMES));
    end_tmo   = start_of_frame && (frame_inc == CNT_W'(END_FRAMES));
  end

  // NOTE: every register here updates with <= so all of them sample the
  // same pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BOOT;
      game_state <= 3'd0;
      lives      <= 3'(LIVES_INIT);
      freeze     <= 1'b1;
      new_game   <= 1'b0;
      respawn    <= 1'b0;
      frame_cnt  <= '0;
      key_q      <= 1'b0;
    end else begin
      key_q    <= start_key;
      new_game <= 1'b0;
      respawn  <= 1'b0;

      case (state)
        S_BOOT: begin
          if (boot_tmo) begin
            state      <= S_START;
            game_state <= 3'd1;
            freeze     <= 1'b1;
            frame_cnt  <= '0;
          end else if (start_of_frame) begin
            frame_cnt <= frame_inc;
          end
        end

        S_START: begin
          if (key_edge) begin
            state      <= S_PLAY;
            game_state <= 3'd2;
            freeze     <= 1'b0;
            lives      <= 3'(LIVES_INIT);
            new_game   <= 1'b1;
            frame_cnt  <= '0;
          end
        end

        S_PLAY: begin
          if (level_done) begin
            state      <= S_WIN;
            game_state <= 3'd3;
            freeze     <= 1'b1;
            frame_cnt  <= '0;
          end else if (player_hit) begin
            freeze    <= 1'b1;
            frame_cnt <= '0;
            if (lives <= 3'd1) begin
              state      <= S_OVER;
              game_state <= 3'd4;
              lives      <= 3'd0;
            end else begin
              state      <= S_DYING;
              game_state <= 3'd2;
              lives      <= lives - 3'd1;
            end
          end
        end

        S_DYING: begin
          if (death_tmo) begin
            state      <= S_PLAY;
            game_state <= 3'd2;
            freeze     <= 1'b0;
            respawn    <= 1'b1;
            frame_cnt  <= '0;
          end else if (start_of_frame) begin
            frame_cnt <= frame_inc;
          end
        end

        S_WIN, S_OVER: begin
          if (end_tmo) begin
            state      <= S_START;
            game_state <= 3'd1;
            freeze     <= 1'b1;
            frame_cnt  <= '0;
          end else if (start_of_frame) begin
            frame_cnt <= frame_inc;
          end
        end

        default: begin
          state      <= S_BOOT;
          game_state <= 3'd0;
          freeze     <= 1'b1;
          frame_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench for game_flow_controller: a vector table for the boot and
// start sequence, then hand-written multi-cycle sequences, all via a scoreboard.
module tb_game_flow_controller;

  typedef struct packed {
    logic [2:0] gs;
    logic [2:0] lv;
    logic       frz;
    logic       ng;
    logic       rs;
  } out_t;

  typedef struct {
    logic  sof;
    logic  key;
    logic  hit;
    logic  done;
    out_t  exp;
    string name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_of_frame;
  logic       start_key;
  logic       player_hit;
  logic       level_done;
  logic [2:0] game_state;
  logic [2:0] lives;
  logic       freeze;
  logic       new_game;
  logic       respawn;

  int    n_tests = 0;
  int    n_fail  = 0;
  out_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[12];

  game_flow_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start_of_frame (start_of_frame),
    .start_key      (start_key),
    .player_hit     (player_hit),
    .level_done     (level_done),
    .game_state     (game_state),
    .lives          (lives),
    .freeze         (freeze),
    .new_game       (new_game),
    .respawn        (respawn)
  );

  always #5 clk = ~clk;

  function automatic out_t eo(input int gs, input int lv, input bit frz, input bit ng, input bit rs);
    out_t o;
    o.gs  = 3'(gs);
    o.lv  = 3'(lv);
    o.frz = frz;
    o.ng  = ng;
    o.rs  = rs;
    return o;
  endfunction

  function automatic vec_t mk(input logic sof, input logic key, input logic hit,
                              input logic done, input out_t e, input string n);
    vec_t v;
    v.sof  = sof;
    v.key  = key;
    v.hit  = hit;
    v.done = done;
    v.exp  = e;
    v.name = n;
    return v;
  endfunction

  task automatic check(input out_t e, input string nm);
    out_t got;
    got = {game_state, lives, freeze, new_game, respawn};
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got gs=%0d lives=%0d freeze=%0b new_game=%0b respawn=%0b, expected gs=%0d lives=%0d freeze=%0b new_game=%0b respawn=%0b",
               nm, got.gs, got.lv, got.frz, got.ng, got.rs, e.gs, e.lv, e.frz, e.ng, e.rs);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, and compare
  // after the edge that consumes it.
  task automatic step(input logic sof, input logic key, input logic hit,
                      input logic done, input out_t e, input string nm);
    out_t  exp_o;
    string exp_n;
    start_of_frame = sof;
    start_key      = key;
    player_hit     = hit;
    level_done     = done;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    start_of_frame = 1'b0;
    player_hit     = 1'b0;
    level_done     = 1'b0;
    exp_o = sb_q.pop_front();
    exp_n = nm_q.pop_front();
    check(exp_o, exp_n);
  endtask

  // n frames, one idle cycle plus one frame pulse each; the last pulse
  // should produce fin, everything before it during.
  task automatic frames(input int n, input logic key, input out_t during,
                        input out_t fin, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b0, key, 1'b0, 1'b0, during, nm);
      step(1'b1, key, 1'b0, 1'b0, (i == n - 1) ? fin : during, nm);
    end
  endtask

  initial begin
    reset          = 1'b1;
    start_of_frame = 1'b0;
    start_key      = 1'b0;
    player_hit     = 1'b0;
    level_done     = 1'b0;

    tbl[0]  = mk(0, 0, 0, 0, eo(0, 3, 1, 0, 0), "boot_idle");
    tbl[1]  = mk(1, 0, 0, 0, eo(0, 3, 1, 0, 0), "boot_sof1");
    tbl[2]  = mk(0, 1, 0, 0, eo(0, 3, 1, 0, 0), "boot_key_ignored");
    tbl[3]  = mk(0, 0, 0, 0, eo(0, 3, 1, 0, 0), "boot_wait");
    tbl[4]  = mk(1, 0, 0, 0, eo(1, 3, 1, 0, 0), "boot_sof2_to_start");
    tbl[5]  = mk(0, 0, 1, 1, eo(1, 3, 1, 0, 0), "start_hit_done_ignored");
    tbl[6]  = mk(1, 0, 0, 0, eo(1, 3, 1, 0, 0), "start_sof_ignored");
    tbl[7]  = mk(0, 1, 0, 0, eo(2, 3, 0, 1, 0), "key_rise_new_game");
    tbl[8]  = mk(0, 1, 0, 0, eo(2, 3, 0, 0, 0), "new_game_one_cycle");
    tbl[9]  = mk(1, 1, 0, 0, eo(2, 3, 0, 0, 0), "play_sof_no_change");
    tbl[10] = mk(0, 0, 0, 0, eo(2, 3, 0, 0, 0), "key_release_in_play");
    tbl[11] = mk(0, 1, 0, 0, eo(2, 3, 0, 0, 0), "key_rise_in_play_ignored");

    // Reset state
    step(0, 0, 0, 0, eo(0, 3, 1, 0, 0), "reset_state");
    step(1, 1, 1, 1, eo(0, 3, 1, 0, 0), "reset_held");
    reset = 1'b0;

    // Boot delay and game start
    for (int i = 0; i < 12; i++)
      step(tbl[i].sof, tbl[i].key, tbl[i].hit, tbl[i].done, tbl[i].exp, tbl[i].name);

    // Held key never re-triggers a new game
    for (int i = 0; i < 100; i++)
      step(0, 1, 0, 0, eo(2, 3, 0, 0, 0), "key_held_no_new_game");

    // First hit, ignored events while dying, respawn after DEATH_FRAMES
    step(0, 1, 1, 0, eo(2, 2, 1, 0, 0), "hit1_dying");
    step(0, 1, 1, 0, eo(2, 2, 1, 0, 0), "hit_in_dying_ignored");
    step(0, 1, 0, 1, eo(2, 2, 1, 0, 0), "done_in_dying_ignored");
    frames(60, 1, eo(2, 2, 1, 0, 0), eo(2, 2, 0, 0, 1), "death_wait1");
    step(0, 1, 0, 0, eo(2, 2, 0, 0, 0), "respawn_one_cycle");

    // Second and third hit, game over, held key through return to start
    step(0, 1, 1, 0, eo(2, 1, 1, 0, 0), "hit2_dying");
    frames(60, 1, eo(2, 1, 1, 0, 0), eo(2, 1, 0, 0, 1), "death_wait2");
    step(0, 1, 0, 0, eo(2, 1, 0, 0, 0), "play_after_respawn2");
    step(0, 1, 1, 0, eo(4, 0, 1, 0, 0), "hit3_game_over");
    step(0, 1, 1, 0, eo(4, 0, 1, 0, 0), "over_hit_no_underflow");
    frames(180, 1, eo(4, 0, 1, 0, 0), eo(1, 0, 1, 0, 0), "over_wait");
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, eo(1, 0, 1, 0, 0), "held_key_no_new_game");
    step(0, 0, 0, 0, eo(1, 0, 1, 0, 0), "start_key_released");
    step(0, 1, 0, 0, eo(2, 3, 0, 1, 0), "new_game_lives_reload");

    // Simultaneous hit and level_done on the last life: win has priority
    step(0, 1, 1, 0, eo(2, 2, 1, 0, 0), "g2_hit1");
    frames(60, 1, eo(2, 2, 1, 0, 0), eo(2, 2, 0, 0, 1), "g2_death_wait1");
    step(0, 1, 1, 0, eo(2, 1, 1, 0, 0), "g2_hit2");
    frames(60, 1, eo(2, 1, 1, 0, 0), eo(2, 1, 0, 0, 1), "g2_death_wait2");
    step(0, 0, 1, 1, eo(3, 1, 1, 0, 0), "hit_and_done_win");
    frames(180, 0, eo(3, 1, 1, 0, 0), eo(1, 1, 1, 0, 0), "win_wait");

    // Reset in the middle of a death count
    step(0, 1, 0, 0, eo(2, 3, 0, 1, 0), "g3_new_game");
    step(0, 1, 1, 0, eo(2, 2, 1, 0, 0), "g3_hit");
    frames(30, 1, eo(2, 2, 1, 0, 0), eo(2, 2, 1, 0, 0), "g3_death_partial");
    reset = 1'b1;
    step(0, 1, 0, 0, eo(0, 3, 1, 0, 0), "reset_mid_dying");
    reset = 1'b0;
    frames(2, 1, eo(0, 3, 1, 0, 0), eo(1, 3, 1, 0, 0), "reboot_to_start");
    frames(40, 1, eo(1, 3, 1, 0, 0), eo(1, 3, 1, 0, 0), "no_respawn_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
